jpegls_bit_packer: RTL and testbench

- Stage-6 entropy coder of the JPEG-LS encoder pipeline; sits directly downstream of the stage-5 pipeline registers.
- Consumes one coded symbol per handshake: regular Golomb residual, run-segment hit, or run-end remainder.
- Serialises each symbol MSB-first into bytes with JPEG-LS 0xFF bit-stuffing.
- Presents bytes on a valid/ready stream to the output writer, and pads/flushes on end-of-frame.

---
 rtl/jpegls_bit_packer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_jpegls_bit_packer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpegls_bit_packer.sv
// jpegls_bit_packer
// Final entropy-coding stage of the JPEG-LS encoder. It accepts one coded
// symbol per handshake, serialises it MSB-first into bytes with 0xFF
// bit-stuffing, and presents the bytes on a valid/ready stream. On
// end-of-frame it zero-pads the last partial byte and marks the final byte.
//
// Symbol types (in_mode):
//   00 regular  : Golomb code of in_errval with parameter in_k (escape when q >= qmax)
//   01 run hit  : single '1'
//   10 run end  : '0' followed by the in_J LSBs of in_run_rem
//   11 reserved : treated as a run hit
//
// Ports:
//   clk, reset (async, active low)
//   in_valid / in_ready   symbol handshake; fields in_mode, in_errval, in_k,
//                         in_limit_sub, in_J, in_run_rem, in_eof
//   out_valid / out_ready byte handshake; out_byte, out_last (final byte of frame)
//   bit_count             only with JPEGLS_BIT_COUNT_EN defined: total emitted
//                         bits including stuff and pad bits, cleared by reset only
//
// State table:
//   IDLE   | waiting for a symbol, in_ready high
//   ZEROS  | emitting the unary zeros (or the leading '0' of a run end)
//   ONE    | emitting the unary terminator '1' (or the run-hit bit)
//   SUFFIX | emitting the binary suffix MSB-first
//   FLUSH  | end of frame: pad the partial byte, clear stuffing state
module jpegls_bit_packer #(
    parameter int modresidual_length = 8,
    parameter int k_length           = 4,
    parameter int J_length           = 5,
    parameter int runcount_length    = 16,
    parameter int LIMIT              = 32,
    parameter int QBPP               = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_mode,
    input  logic [modresidual_length-1:0] in_errval,
    input  logic [k_length-1:0]           in_k,
    input  logic [J_length-1:0]           in_limit_sub,
    input  logic [J_length-1:0]           in_J,
    input  logic [runcount_length-1:0]    in_run_rem,
    input  logic                          in_eof,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_last
`ifdef JPEGLS_BIT_COUNT_EN
    ,
    output logic [31:0]                   bit_count
`endif
);

    localparam int ZW = modresidual_length;
    localparam int SW = 6;
    localparam int VW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ZEROS  = 3'd1,
        ONE    = 3'd2,
        SUFFIX = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    state_t state_q, state_d, first_d, end_state;

    // latched symbol
    logic [ZW-1:0] zcnt_q;
    logic          one_q;
    logic [SW-1:0] scnt_q;
    logic [VW-1:0] sval_q;
    logic          eof_q;

    // symbol decode at accept
    logic [ZW-1:0] q_val;
    logic [ZW-1:0] errval_m1;
    int            qmax_i;
    logic          escape;
    logic [ZW-1:0] nz_d;
    logic          one_d;
    logic [SW-1:0] slen_d;
    logic [VW-1:0] src_d;
    logic [VW-1:0] sval_d;

    // byte builder
    logic [7:0] acc_q;
    logic [3:0] acc_cnt_q;
    logic       stuff_q;
    logic [3:0] cap;
    logic [7:0] done_byte;
    logic [7:0] pad_byte;

    logic accept;
    logic emit_valid;
    logic emit_bit;
    logic byte_done;
    logic out_busy;
    logic stall;
    logic adv;
    logic sym_end;
    logic flush_load;
    logic load_out;
    logic [7:0] load_byte;
    logic load_last;

    always_comb begin
        q_val     = in_errval >> in_k;
        errval_m1 = in_errval - {{(ZW-1){1'b0}}, 1'b1};
        qmax_i    = LIMIT - int'(in_limit_sub) - QBPP - 1;
        if (qmax_i < 0) qmax_i = 0;
        escape    = int'(q_val) >= qmax_i;
        nz_d      = '0;
        one_d     = 1'b1;
        slen_d    = '0;
        src_d     = '0;
        case (in_mode)
            2'b00: begin
                if (escape) begin
                    nz_d   = ZW'(qmax_i);
                    slen_d = SW'(QBPP);
                    src_d  = VW'(errval_m1);
                end else begin
                    nz_d   = q_val;
                    slen_d = SW'(in_k);
                    src_d  = VW'(in_errval);
                end
            end
            2'b10: begin
                nz_d   = ZW'(1);
                one_d  = 1'b0;
                slen_d = SW'(in_J);
                src_d  = VW'(in_run_rem);
            end
            default: begin
                nz_d   = '0;
                one_d  = 1'b1;
            end
        endcase
        // Left-align the suffix so the next bit to send is always bit VW-1.
        sval_d = src_d << (SW'(VW) - slen_d);
        if (nz_d != '0)  first_d = ZEROS;
        else if (one_d)  first_d = ONE;
        else             first_d = SUFFIX;
    end

    assign end_state  = eof_q ? FLUSH : IDLE;
    assign accept     = in_valid & in_ready;
    assign emit_valid = (state_q == ZEROS) | (state_q == ONE) | (state_q == SUFFIX);
    assign emit_bit   = (state_q == ONE) | ((state_q == SUFFIX) & sval_q[VW-1]);

    // After a 0xFF byte the next byte holds only 7 data bits; its MSB stays 0.
    assign cap        = stuff_q ? 4'd7 : 4'd8;
    assign byte_done  = emit_valid & ((acc_cnt_q + 4'd1) == cap);
    assign out_busy   = out_valid & ~out_ready;
    assign stall      = byte_done & out_busy;
    assign adv        = emit_valid & ~stall;
    assign done_byte  = {acc_q[6:0], emit_bit};
    assign pad_byte   = acc_q << (cap - acc_cnt_q);
    assign flush_load = (state_q == FLUSH) & (acc_cnt_q != 4'd0) & ~out_busy;

    always_comb begin
        state_d  = state_q;
        sym_end  = 1'b0;
        in_ready = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = first_d;
            end
            ZEROS: begin
                if (adv && zcnt_q == ZW'(1)) begin
                    if (one_q) begin
                        state_d = ONE;
                    end else if (scnt_q != '0) begin
                        state_d = SUFFIX;
                    end else begin
                        sym_end = 1'b1;
                        state_d = end_state;
                    end
                end
            end
            ONE: begin
                if (adv) begin
                    if (scnt_q != '0) begin
                        state_d = SUFFIX;
                    end else begin
                        sym_end = 1'b1;
                        state_d = end_state;
                    end
                end
            end
            SUFFIX: begin
                if (adv && scnt_q == SW'(1)) begin
                    sym_end = 1'b1;
                    state_d = end_state;
                end
            end
            FLUSH: begin
                // An empty accumulator means the final byte already left
                // with out_last set, so there is nothing to pad.
                if (acc_cnt_q == 4'd0 || !out_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            zcnt_q  <= '0;
            one_q   <= 1'b0;
            scnt_q  <= '0;
            sval_q  <= '0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                zcnt_q <= nz_d;
                one_q  <= one_d;
                scnt_q <= slen_d;
                sval_q <= sval_d;
                eof_q  <= in_eof;
            end else if (adv) begin
                if (state_q == ZEROS) zcnt_q <= zcnt_q - ZW'(1);
                if (state_q == SUFFIX) begin
                    scnt_q <= scnt_q - SW'(1);
                    sval_q <= sval_q << 1;
                end
            end
        end
    end

    assign load_out  = (adv & byte_done) | flush_load;
    assign load_byte = flush_load ? pad_byte : done_byte;
    assign load_last = flush_load | (sym_end & eof_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
            stuff_q   <= 1'b0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (adv) begin
                if (byte_done) begin
                    acc_q     <= '0;
                    acc_cnt_q <= '0;
                    stuff_q   <= (done_byte == 8'hFF);
                end else begin
                    acc_q     <= done_byte;
                    acc_cnt_q <= acc_cnt_q + 4'd1;
                end
            end else if (flush_load) begin
                acc_q     <= '0;
                acc_cnt_q <= '0;
            end
            if (state_q == FLUSH && state_d == IDLE) stuff_q <= 1'b0;

            if (load_out) begin
                out_valid <= 1'b1;
                out_byte  <= load_byte;
                out_last  <= load_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef JPEGLS_BIT_COUNT_EN
    // Stuff bits are counted when their byte completes; pad bits at flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_count <= '0;
        end else if (adv) begin
            bit_count <= bit_count + 32'd1 + ((byte_done && stuff_q) ? 32'd1 : 32'd0);
        end else if (flush_load) begin
            bit_count <= bit_count + 32'(cap - acc_cnt_q) + (stuff_q ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_jpegls_bit_packer.sv
module tb_jpegls_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [7:0]  in_errval;
    logic [3:0]  in_k;
    logic [4:0]  in_limit_sub;
    logic [4:0]  in_J;
    logic [15:0] in_run_rem;
    logic        in_eof;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
`ifdef JPEGLS_BIT_COUNT_EN
    logic [31:0] bit_count;
`endif

    jpegls_bit_packer dut (
        .clk          (clk),
        .reset        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_errval    (in_errval),
        .in_k         (in_k),
        .in_limit_sub (in_limit_sub),
        .in_J         (in_J),
        .in_run_rem   (in_run_rem),
        .in_eof       (in_eof),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_byte     (out_byte),
        .out_last     (out_last)
`ifdef JPEGLS_BIT_COUNT_EN
        ,
        .bit_count    (bit_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int b;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;     // 0: always ready, 1: random, 2: held low
    bit   sb_model = 0;     // 1: model pushes expectations, 0: directed constants

    // reference byte stream state
    int m_acc = 0;
    int m_n = 0;
    bit m_stuff = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int b, input int last);
        exp_t e;
        e.b = b;
        e.last = last;
        exp_q.push_back(e);
    endfunction

    function automatic void model_bit(input int b);
        int cap;
        cap = m_stuff ? 7 : 8;
        m_acc = m_acc * 2 + b;
        m_n++;
        if (m_n == cap) begin
            if (sb_model) push_exp(m_acc, 0);
            m_stuff = (m_acc == 255);
            m_acc = 0;
            m_n = 0;
        end
    endfunction

    function automatic void model_sym(input int mode, input int errval, input int k,
                                      input int lsub, input int j, input int rem, input int eof);
        int q, qmax, v, cap;
        if (mode == 0) begin
            q = errval >> k;
            qmax = 32 - lsub - 8 - 1;
            if (qmax < 0) qmax = 0;
            if (q < qmax) begin
                for (int i = 0; i < q; i++) model_bit(0);
                model_bit(1);
                for (int i = k - 1; i >= 0; i--) model_bit((errval >> i) & 1);
            end else begin
                v = (errval - 1) & 255;
                for (int i = 0; i < qmax; i++) model_bit(0);
                model_bit(1);
                for (int i = 7; i >= 0; i--) model_bit((v >> i) & 1);
            end
        end else if (mode == 2) begin
            model_bit(0);
            for (int i = j - 1; i >= 0; i--) model_bit((rem >> i) & 1);
        end else begin
            model_bit(1);
        end
        if (eof != 0) begin
            cap = m_stuff ? 7 : 8;
            if (m_n > 0) begin
                if (sb_model) push_exp((m_acc << (cap - m_n)) & 255, 1);
            end else if (sb_model && exp_q.size() > 0) begin
                exp_q[exp_q.size() - 1].last = 1;
            end
            m_acc = 0;
            m_n = 0;
            m_stuff = 0;
        end
    endfunction

    // out_ready driver: changes only just after the rising edge
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // monitor: a transfer happens at the next rising edge when valid&ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", out_byte, 256);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_byte", out_byte, e.b);
                chk("out_last", out_last, e.last);
            end
        end
    end

    task automatic issue(input int mode, input int errval, input int k, input int lsub,
                         input int j, input int rem, input int eof);
        int n;
        model_sym(mode, errval, k, lsub, j, rem, eof);
        in_mode      = 2'(mode);
        in_errval    = 8'(errval);
        in_k         = 4'(k);
        in_limit_sub = 5'(lsub);
        in_J         = 5'(j);
        in_run_rem   = 16'(rem);
        in_eof       = (eof != 0);
        in_valid     = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 2000) break;
        end
        if (n >= 2000) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 5000 && !(exp_q.size() == 0 && !out_valid && in_ready)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("drain_timeout_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int low;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_mode = '0;
        in_errval = '0;
        in_k = '0;
        in_limit_sub = '0;
        in_J = '0;
        in_run_rem = '0;
        in_eof = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // regular k=2 errval=9: 00101 + pad
        push_exp(8'h28, 1);
        issue(0, 9, 2, 0, 0, 0, 1);
        drain();

        // same symbol without eof: busy for exactly 5 cycles after accept
        push_exp(8'h2C, 1);
        issue(0, 9, 2, 0, 0, 0, 0);
        low = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
            low++;
        end
        chk("in_ready_low_cycles", low, 5);
        @(posedge clk);
        #1;
        issue(1, 0, 0, 0, 0, 0, 1);
        drain();

        // escape code
        push_exp(8'h00, 0);
        push_exp(8'h00, 0);
        push_exp(8'h01, 0);
        push_exp(8'h1D, 1);
        issue(0, 30, 0, 0, 0, 0, 1);
        drain();

        // stuffing: 8 hits -> 0xFF, 7 more (some via reserved mode) -> 0x7F
        push_exp(8'hFF, 0);
        push_exp(8'h7F, 1);
        for (int i = 0; i < 15; i++) issue((i % 4 == 3) ? 3 : 1, 0, 0, 0, 0, 0, (i == 14) ? 1 : 0);
        drain();

        // run end J=3 rem=5, then J=0
        push_exp(8'h50, 1);
        issue(2, 0, 0, 0, 3, 5, 1);
        drain();
        push_exp(8'h00, 1);
        issue(2, 0, 0, 0, 0, 5, 1);
        drain();

        // backpressure
        rdy_mode = 2;
        push_exp(8'hFF, 0);
        push_exp(8'h7F, 0);
        push_exp(8'h80, 1);
        for (int i = 0; i < 15; i++) issue(1, 0, 0, 0, 0, 0, 0);
        low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!in_ready) low++;
        end
        chk("bp_in_ready_low", low, 10);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_byte", out_byte, 8'hFF);
        rdy_mode = 0;
        issue(1, 0, 0, 0, 0, 0, 1);
        drain();

        // reset in the middle of an escape symbol with a byte held
        rdy_mode = 2;
        issue(0, 30, 0, 0, 0, 0, 1);
        repeat (12) @(posedge clk);
        #2;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_in_ready", in_ready, 1);
        exp_q.delete();
        m_acc = 0;
        m_n = 0;
        m_stuff = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        push_exp(8'h28, 1);
        issue(0, 9, 2, 0, 0, 0, 1);
        drain();

        // randomized traffic against the reference model
        sb_model = 1;
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 10),
                  $urandom_range(0, 16), $urandom_range(0, 20), $urandom_range(0, 65535),
                  (($urandom_range(0, 7) == 0) || (i == 399)) ? 1 : 0);
        end
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
